bytes_sobel: RTL and testbench



---
 rtl/bytes_sobel_pkg.sv | 30 +++
 rtl/bytes_sobel_kernel.sv | 46 ++++
 rtl/bytes_sobel.sv | 197 +++++++++++++++++++
 tb/tb_bytes_sobel.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bytes_sobel_pkg.sv
// Shared widths, D bit positions and pixel helpers for the bytes_sobel edge detector.
// The 3-bytes-per-pixel front end is selected at build time with BYTES_RGB_EN.
package bytes_sobel_pkg;

   localparam int LINE_W_DEFAULT  = 637;
   localparam int FRAME_H_DEFAULT = 480;

   localparam int PIX_W     = 8;
   localparam int GRAD_W    = 11;
   localparam int MAG_W     = 11;
   localparam int D_W       = 13;
   localparam int VALID_BIT = 11;
   localparam int WIN_BIT   = 12;

   typedef logic [PIX_W-1:0]        pix_t;
   typedef logic signed [GRAD_W-1:0] grad_t;
   typedef logic [MAG_W-1:0]        mag_t;

   // The weighted sum R + 2G + B needs 10 bits; dividing by 4 brings it back to a byte.
   function automatic pix_t rgb_to_gray(input pix_t red, input pix_t green, input pix_t blue);
      logic [9:0] sum;
      sum = {2'b00, red} + {1'b0, green, 1'b0} + {2'b00, blue};
      return pix_t'(sum >> 2);
   endfunction

   function automatic pix_t saturate(input mag_t mag);
      return (mag > mag_t'(255)) ? pix_t'(8'hFF) : mag[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/bytes_sobel_kernel.sv
// Combinational Sobel operator: Gx/Gy from a row-major 3x3 window, |Gx|+|Gy| and byte saturation.
module sobel_kernel
   import bytes_sobel_pkg::*;
(
   input  logic [PIX_W-1:0] p0,
   input  logic [PIX_W-1:0] p1,
   input  logic [PIX_W-1:0] p2,
   input  logic [PIX_W-1:0] p3,
   input  logic [PIX_W-1:0] p4,
   input  logic [PIX_W-1:0] p5,
   input  logic [PIX_W-1:0] p6,
   input  logic [PIX_W-1:0] p7,
   input  logic [PIX_W-1:0] p8,
   output logic [MAG_W-1:0] mag,
   output logic [PIX_W-1:0] mag_sat
);

   logic [GRAD_W-1:0] gx_pos;
   logic [GRAD_W-1:0] gx_neg;
   logic [GRAD_W-1:0] gy_pos;
   logic [GRAD_W-1:0] gy_neg;
   grad_t             gx;
   grad_t             gy;
   mag_t              abs_gx;
   mag_t              abs_gy;

   // The centre pixel carries no weight in either direction.
   logic unused_center;
   assign unused_center = ^p4;

   // Each weighted sum peaks at 1020, so the difference fits 11-bit signed.
   assign gx_pos = GRAD_W'(p2) + (GRAD_W'(p5) << 1) + GRAD_W'(p8);
   assign gx_neg = GRAD_W'(p0) + (GRAD_W'(p3) << 1) + GRAD_W'(p6);
   assign gy_pos = GRAD_W'(p6) + (GRAD_W'(p7) << 1) + GRAD_W'(p8);
   assign gy_neg = GRAD_W'(p0) + (GRAD_W'(p1) << 1) + GRAD_W'(p2);

   assign gx = grad_t'(gx_pos - gx_neg);
   assign gy = grad_t'(gy_pos - gy_neg);

   assign abs_gx = gx[GRAD_W-1] ? mag_t'(-gx) : mag_t'(gx);
   assign abs_gy = gy[GRAD_W-1] ? mag_t'(-gy) : mag_t'(gy);

   assign mag     = abs_gx + abs_gy;
   assign mag_sat = saturate(mag);

endmodule

// File: rtl/bytes_sobel.sv
// Streaming 3x3 Sobel edge detector fed by a toggle-strobed byte bus.
// Build option BYTES_RGB_EN: group bytes as R,G,B and convert to gray; otherwise each byte is a gray pixel.
module bytes_sobel
   import bytes_sobel_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEFAULT,
   parameter int FRAME_H = FRAME_H_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             DATAIN,
   input  logic [PIX_W-1:0] DATA,
   output logic [PIX_W-1:0] IN0,
   output logic [PIX_W-1:0] IN1,
   output logic [PIX_W-1:0] IN2,
   output logic [PIX_W-1:0] IN3,
   output logic [PIX_W-1:0] IN4,
   output logic [PIX_W-1:0] IN5,
   output logic [PIX_W-1:0] IN6,
   output logic [PIX_W-1:0] IN7,
   output logic [PIX_W-1:0] IN8,
   output logic [D_W-1:0]   D,
   output logic [PIX_W-1:0] DATARES,
   output logic             DATAOUT
);

   localparam int COL_W = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
   localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);

   logic       sync_1;
   logic       sync_2;
   logic       sync_3;
   logic       byte_stb;
   pix_t       byte_reg;

   logic       pix_stb;
   pix_t       gray;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   pix_t             linebuf0 [LINE_W];
   pix_t             linebuf1 [LINE_W];
   pix_t             lb0_rd;
   pix_t             lb1_rd;

   pix_t       win [9];
   logic       win_flag;
   logic       res_pend;

   mag_t       kern_mag;
   pix_t       kern_sat;
   mag_t       mag_reg;
   logic       valid_pulse;

   // Two flops of synchronisation plus one more to compare against; any change is a byte.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_3   <= 1'b0;
         byte_stb <= 1'b0;
         byte_reg <= '0;
      end else begin
         sync_1   <= DATAIN;
         sync_2   <= sync_1;
         sync_3   <= sync_2;
         byte_stb <= sync_2 ^ sync_3;
         if (sync_2 ^ sync_3) begin
            byte_reg <= DATA;
         end
      end
   end

`ifdef BYTES_RGB_EN
   logic [1:0] byte_cnt;
   pix_t       red_reg;
   pix_t       green_reg;

   // The blue byte is consumed straight from byte_reg, so the pixel fires in the same cycle as its strobe.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         byte_cnt  <= 2'd0;
         red_reg   <= '0;
         green_reg <= '0;
      end else if (byte_stb) begin
         case (byte_cnt)
            2'd0: begin
               red_reg  <= byte_reg;
               byte_cnt <= 2'd1;
            end
            2'd1: begin
               green_reg <= byte_reg;
               byte_cnt  <= 2'd2;
            end
            default: begin
               byte_cnt <= 2'd0;
            end
         endcase
      end
   end

   assign pix_stb = byte_stb && (byte_cnt == 2'd2);
   assign gray    = rgb_to_gray(red_reg, green_reg, byte_reg);
`else
   assign pix_stb = byte_stb;
   assign gray    = byte_reg;
`endif

   assign lb0_rd = linebuf0[col];
   assign lb1_rd = linebuf1[col];

   // Line buffers are never cleared; stale contents stay invisible until two fresh rows exist.
   always_ff @(posedge CLK) begin
      if (RST_N && pix_stb) begin
         linebuf1[col] <= lb0_rd;
         linebuf0[col] <= gray;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
         col      <= '0;
         row      <= '0;
         win_flag <= 1'b0;
         res_pend <= 1'b0;
      end else begin
         res_pend <= pix_stb;
         if (pix_stb) begin
            for (int r = 0; r < 3; r++) begin
               win[3*r]     <= win[3*r + 1];
               win[3*r + 1] <= win[3*r + 2];
            end
            win[2] <= lb1_rd;
            win[5] <= lb0_rd;
            win[8] <= gray;
            // Requiring col >= 2 keeps the window from straddling a row seam.
            win_flag <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   sobel_kernel u_kernel (
      .p0      (win[0]),
      .p1      (win[1]),
      .p2      (win[2]),
      .p3      (win[3]),
      .p4      (win[4]),
      .p5      (win[5]),
      .p6      (win[6]),
      .p7      (win[7]),
      .p8      (win[8]),
      .mag     (kern_mag),
      .mag_sat (kern_sat)
   );

   // Results hold between issues so a consumer can sample them on the falling edge of the pulse.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mag_reg     <= '0;
         DATARES     <= '0;
         valid_pulse <= 1'b0;
         DATAOUT     <= 1'b0;
      end else begin
         valid_pulse <= 1'b0;
         if (res_pend && win_flag) begin
            mag_reg     <= kern_mag;
            DATARES     <= kern_sat;
            valid_pulse <= 1'b1;
            DATAOUT     <= ~DATAOUT;
         end
      end
   end

   assign D = {win_flag, valid_pulse, mag_reg};

   assign IN0 = win[0];
   assign IN1 = win[1];
   assign IN2 = win[2];
   assign IN3 = win[3];
   assign IN4 = win[4];
   assign IN5 = win[5];
   assign IN6 = win[6];
   assign IN7 = win[7];
   assign IN8 = win[8];

endmodule

// File: tb/tb_bytes_sobel.sv
// Scoreboard bench for bytes_sobel on a small image: a pixel-level model queues expected results,
// a monitor pops them on every result pulse. Sends R=G=B when BYTES_RGB_EN is defined.
module tb_bytes_sobel;

   localparam int LW = 16;
   localparam int FH = 8;
   localparam int PER_FRAME = (LW - 2) * (FH - 2);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        datain;
   logic [7:0]  data;
   logic [7:0]  in0, in1, in2, in3, in4, in5, in6, in7, in8;
   logic [12:0] d;
   logic [7:0]  datares;
   logic        dataout;

   typedef struct {
      int          mag;
      int          sat;
      logic [71:0] win;
   } exp_t;

   exp_t exp_q[$];
   int   img [FH][LW];
   int   m_row;
   int   m_col;
   int   checks = 0;
   int   errors = 0;
   int   pulse_count = 0;
   logic exp_dout = 1'b0;
   logic prev_pulse = 1'b0;
   logic [7:0] last_sat = 8'h00;

   always #5 clk = ~clk;

   bytes_sobel #(.LINE_W(LW), .FRAME_H(FH)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .DATAIN  (datain),
      .DATA    (data),
      .IN0     (in0),
      .IN1     (in1),
      .IN2     (in2),
      .IN3     (in3),
      .IN4     (in4),
      .IN5     (in5),
      .IN6     (in6),
      .IN7     (in7),
      .IN8     (in8),
      .D       (d),
      .DATARES (datares),
      .DATAOUT (dataout)
   );

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic sendByte(input logic [7:0] value);
      @(negedge clk);
      data   = value;
      datain = ~datain;
      repeat (2 + $urandom_range(0, 2)) @(negedge clk);
   endtask

   // Model: record the pixel, and if it completes a 3x3 window inside the row, queue the Sobel result.
   task automatic applyStimulus(input int gray);
      int w [9];
      int gx, gy, mag;
      exp_t e;
      img[m_row][m_col] = gray;
      if (m_row >= 2 && m_col >= 2) begin
         e.win = '0;
         for (int k = 0; k < 9; k++) begin
            w[k]  = img[m_row - 2 + k / 3][m_col - 2 + k % 3];
            e.win = {e.win[63:0], 8'(w[k])};
         end
         gx    = (w[2] + 2 * w[5] + w[8]) - (w[0] + 2 * w[3] + w[6]);
         gy    = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
         mag   = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         e.mag = mag;
         e.sat = (mag > 255) ? 255 : mag;
         exp_q.push_back(e);
      end
      m_col++;
      if (m_col == LW) begin
         m_col = 0;
         m_row = (m_row == FH - 1) ? 0 : m_row + 1;
      end
`ifdef BYTES_RGB_EN
      sendByte(8'(gray));
      sendByte(8'(gray));
      sendByte(8'(gray));
`else
      sendByte(8'(gray));
`endif
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n  = 1'b0;
      datain = 1'b0;
      data   = 8'h00;
      repeat (4) @(negedge clk);
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      rst_n = 1'b1;
   endtask

   task automatic checkReset();
      checkOutput("reset_d", 72'(d), 72'h0);
      checkOutput("reset_datares", 72'(datares), 72'h0);
      checkOutput("reset_dataout", 72'(dataout), 72'h0);
      checkOutput("reset_window", {in0, in1, in2, in3, in4, in5, in6, in7, in8}, 72'h0);
   endtask

   task automatic drain();
      int budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (4) @(negedge clk);
      checkOutput("drain_pending", 72'(exp_q.size()), 72'h0);
   endtask

   // Pattern 0 random, 1 uniform, 2 vertical step, 3 horizontal step, 4 single bright pixel.
   task automatic sendFrame(input int pattern);
      int start = pulse_count;
      int g;
      for (int r = 0; r < FH; r++) begin
         for (int c = 0; c < LW; c++) begin
            case (pattern)
               0:       g = int'($urandom_range(0, 255));
               1:       g = 8'h80;
               2:       g = (c < LW / 2) ? 8'h00 : 8'h40;
               3:       g = (r < FH / 2) ? 8'h10 : 8'h20;
               default: g = (r == 4 && c == 4) ? 8'hFF : 8'h00;
            endcase
            applyStimulus(g);
         end
      end
      drain();
      checkOutput($sformatf("frame_pulses_p%0d", pattern), 72'(pulse_count - start), 72'(PER_FRAME));
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_dout   = 1'b0;
         prev_pulse = 1'b0;
      end else begin
         if (prev_pulse) begin
            checkOutput("pulse_width", 72'(d[11]), 72'h0);
            checkOutput("datares_hold", 72'(datares), 72'(last_sat));
         end
         if (d[11]) begin
            pulse_count++;
            exp_dout = ~exp_dout;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: got mag %0d, expected no result at %0t", d[10:0], $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("mag", 72'(d[10:0]), 72'(e.mag));
               checkOutput("datares", 72'(datares), 72'(e.sat));
               checkOutput("window", {in0, in1, in2, in3, in4, in5, in6, in7, in8}, e.win);
               checkOutput("win_flag", 72'(d[12]), 72'h1);
               checkOutput("dataout", 72'(dataout), 72'(exp_dout));
            end
            last_sat = datares;
         end
         prev_pulse = d[11];
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int start;
      rst_n  = 1'b0;
      datain = 1'b0;
      data   = 8'h00;
      m_row  = 0;
      m_col  = 0;
      doReset();
      checkReset();

      sendFrame(0);
      sendFrame(1);
      sendFrame(2);
      sendFrame(3);
      sendFrame(4);

      // Stop partway through row 1, leave a partial pixel in flight, then reset.
      for (int i = 0; i < LW + 5; i++) begin
         applyStimulus(int'($urandom_range(0, 255)));
      end
`ifdef BYTES_RGB_EN
      sendByte(8'h55);
      sendByte(8'hAA);
`else
      @(negedge clk);
      data   = 8'h99;
      datain = ~datain;
`endif
      drain();
      doReset();
      checkReset();

      // No result may appear until the third pixel of row 2.
      start = pulse_count;
      for (int i = 0; i < 2 * LW + 2; i++) begin
         applyStimulus(int'($urandom_range(0, 255)));
      end
      repeat (10) @(negedge clk);
      checkOutput("no_early_result", 72'(pulse_count - start), 72'h0);
      applyStimulus(int'($urandom_range(0, 255)));
      drain();
      checkOutput("first_result", 72'(pulse_count - start), 72'h1);
      for (int i = 2 * LW + 3; i < LW * FH; i++) begin
         applyStimulus(int'($urandom_range(0, 255)));
      end
      drain();
      checkOutput("restart_frame_pulses", 72'(pulse_count - start), 72'(PER_FRAME));

      sendFrame(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
